// File: rtl/slow_clock_monitor.sv
// slow_clock_monitor
//
// Receives the toggling slow clock from the divider and prepares it for use in
// the Clk domain. It produces clean one-cycle tick pulses and measures every
// half-period in Clk cycles. It also flags a stalled source and keeps a 0-59
// seconds count for the game timing logic.
//
// Ports:
//   Clk          in   system clock
//   Reset        in   synchronous, active-high; clears every flop
//   slow_in      in   slow square wave, asynchronous to Clk
//   tick         out  one-cycle pulse per detected rising edge of slow_in
//   edge_any     out  one-cycle pulse per detected edge of either polarity
//   half_period  out  Clk cycles in the last completed edge-to-edge interval
//   period_valid out  half_period holds a measurement taken since reset/stall
//   in_tol       out  half_period lies within EXP_HALF +/- TOL
//   stalled      out  no edge seen for TIMEOUT cycles
//   seconds      out  count of tick pulses, modulo 60
module slow_clock_monitor #(
  parameter int unsigned EXP_HALF = 25_000_001,
  parameter int unsigned TOL      = 1000,
  parameter int unsigned TIMEOUT  = 50_000_002,
  parameter int unsigned CW       = 28
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          slow_in,
  output logic          tick,
  output logic          edge_any,
  output logic [CW-1:0] half_period,
  output logic          period_valid,
  output logic          in_tol,
  output logic          stalled,
  output logic [5:0]    seconds
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STALLED
  } state_t;

  // The tolerance window is compared one bit wider than the counter.
  // The lower bound is clamped at zero, so a small EXP_HALF cannot wrap it.
  localparam logic [CW:0]   TOL_LO    = (CW+1)'(EXP_HALF >= TOL ? EXP_HALF - TOL : 0);
  localparam logic [CW:0]   TOL_HI    = (CW+1)'(EXP_HALF + TOL);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          s3_q, s3_d;
  logic          tick_q, tick_d;
  logic          edge_any_q, edge_any_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] half_period_q, half_period_d;
  logic          period_valid_q, period_valid_d;
  logic          in_tol_q, in_tol_d;
  logic          stalled_q, stalled_d;
  logic [5:0]    seconds_q, seconds_d;

  logic          rise_det;
  logic          edge_det;
  logic          cnt_in_tol;

  // s1/s2 form the synchronizer and s3 holds the previous synchronized level.
  // Edges are detected between s2 and s3 and then registered once more.
  // This makes tick and edge_any glitch-free, one-cycle pulses.
  always_comb begin
    s1_d       = slow_in;
    s2_d       = s1_q;
    s3_d       = s2_q;
    rise_det   = s2_q & ~s3_q;
    edge_det   = s2_q ^ s3_q;
    tick_d     = rise_det;
    edge_any_d = edge_det;
  end

  // Tolerance test applied to the count captured by the current edge.
  always_comb begin
    cnt_in_tol = ({1'b0, cnt_q} >= TOL_LO) && ({1'b0, cnt_q} <= TOL_HI);
  end

  // Measurement FSM. In MEASURE, cnt_q equals the number of cycles since the
  // previous detected edge, so an edge captures it directly as half_period.
  // The edge is checked before the timeout. A late edge that coincides with
  // the timeout is still recorded and does not enter STALLED.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    half_period_d  = half_period_q;
    period_valid_d = period_valid_q;
    in_tol_d       = in_tol_q;
    stalled_d      = stalled_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (edge_det) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
        end
      end

      MEASURE: begin
        if (edge_det) begin
          half_period_d  = cnt_q;
          period_valid_d = 1'b1;
          in_tol_d       = cnt_in_tol;
          cnt_d          = CNT_ONE;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d        = STALLED;
          stalled_d      = 1'b1;
          period_valid_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STALLED: begin
        // The first edge after a stall only restarts timing. The interval
        // that ended with it is meaningless, so nothing is recorded.
        if (edge_det) begin
          state_d   = MEASURE;
          stalled_d = 1'b0;
          cnt_d     = CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The seconds counter follows the registered tick. Stalls do not clear it;
  // only Reset does.
  always_comb begin
    seconds_d = seconds_q;
    if (tick_q) begin
      seconds_d = (seconds_q == 6'd59) ? 6'd0 : seconds_q + 6'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      tick_q         <= 1'b0;
      edge_any_q     <= 1'b0;
      cnt_q          <= '0;
      half_period_q  <= '0;
      period_valid_q <= 1'b0;
      in_tol_q       <= 1'b0;
      stalled_q      <= 1'b0;
      seconds_q      <= 6'd0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      tick_q         <= tick_d;
      edge_any_q     <= edge_any_d;
      cnt_q          <= cnt_d;
      half_period_q  <= half_period_d;
      period_valid_q <= period_valid_d;
      in_tol_q       <= in_tol_d;
      stalled_q      <= stalled_d;
      seconds_q      <= seconds_d;
    end
  end

  assign tick         = tick_q;
  assign edge_any     = edge_any_q;
  assign half_period  = half_period_q;
  assign period_valid = period_valid_q;
  assign in_tol       = in_tol_q;
  assign stalled      = stalled_q;
  assign seconds      = seconds_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// tb_slow_clock_monitor
//
// Directed bench for slow_clock_monitor, built with EXP_HALF=10, TOL=1,
// TIMEOUT=40 and CW=8. Inputs change 1 time unit after a rising Clk edge,
// and outputs are sampled at the same point.
//
// A slow_in change made just after edge P0 is captured by s1 at P1 and by s2
// at P2. The registered pulse is visible after P3 and gone after P4.
module tb_slow_clock_monitor;

  logic       Clk;
  logic       Reset;
  logic       slow_in;
  logic       tick;
  logic       edge_any;
  logic [7:0] half_period;
  logic       period_valid;
  logic       in_tol;
  logic       stalled;
  logic [5:0] seconds;

  int checks;
  int errors;
  int rises;

  slow_clock_monitor #(
    .EXP_HALF(10),
    .TOL     (1),
    .TIMEOUT (40),
    .CW      (8)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .slow_in     (slow_in),
    .tick        (tick),
    .edge_any    (edge_any),
    .half_period (half_period),
    .period_valid(period_valid),
    .in_tol      (in_tol),
    .stalled     (stalled),
    .seconds     (seconds)
  );

  // 10-unit clock period.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock and settle just past the active edge.
  task automatic stepCycle();
    @(posedge Clk);
    #1;
  endtask

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_tick"},     32'(tick), 0);
    checkOutput({tag, "_edge"},     32'(edge_any), 0);
    checkOutput({tag, "_hp"},       32'(half_period), 0);
    checkOutput({tag, "_valid"},    32'(period_valid), 0);
    checkOutput({tag, "_tol"},      32'(in_tol), 0);
    checkOutput({tag, "_stalled"},  32'(stalled), 0);
    checkOutput({tag, "_seconds"},  32'(seconds), 0);
  endtask

  // Drive slow_in to 'value' and hold it for 'len' cycles. The task checks:
  //   - no pulse during the two synchronizer cycles,
  //   - the edge pulse and measurement outputs on the third cycle,
  //   - the pulse dropping after one cycle,
  //   - the seconds count once the tick has been absorbed (len >= 4).
  task automatic applyStimulus(input logic value, input int len,
                               input int expTick, input int expHp,
                               input int expValid, input int expTol,
                               input int expSeconds);
    slow_in = value;
    stepCycle();
    checkOutput("sync1_edge", 32'(edge_any), 0);
    stepCycle();
    checkOutput("sync2_edge", 32'(edge_any), 0);
    stepCycle();
    checkOutput("edge_pulse",   32'(edge_any), 1);
    checkOutput("tick_pulse",   32'(tick), 32'(expTick));
    checkOutput("half_period",  32'(half_period), 32'(expHp));
    checkOutput("period_valid", 32'(period_valid), 32'(expValid));
    checkOutput("in_tol",       32'(in_tol), 32'(expTol));
    checkOutput("stalled_edge", 32'(stalled), 0);
    for (int i = 3; i < len; i++) begin
      stepCycle();
      if (i == 3) begin
        checkOutput("edge_width", 32'(edge_any), 0);
        checkOutput("tick_width", 32'(tick), 0);
      end
    end
    if (len >= 4) begin
      checkOutput("seconds", 32'(seconds), 32'(expSeconds));
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    Reset   = 1'b1;
    slow_in = 1'b0;

    // Reset held for three cycles with slow_in low.
    stepCycle();
    stepCycle();
    stepCycle();
    checkAllZero("reset");
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("idle_tick", 32'(tick), 0);
    end

    // Nominal 10-cycle toggling. The first edge leaves IDLE without recording.
    //            val len tick hp valid tol sec
    applyStimulus(1, 10, 1,  0, 0, 0, 1);
    applyStimulus(0, 10, 0, 10, 1, 1, 1);
    applyStimulus(1, 10, 1, 10, 1, 1, 2);

    // Tolerance bounds: intervals of 9, 11, 8 and 12 cycles.
    applyStimulus(0,  9, 0, 10, 1, 1, 2);
    applyStimulus(1, 11, 1,  9, 1, 1, 3);
    applyStimulus(0,  8, 0, 11, 1, 1, 3);
    applyStimulus(1, 12, 1,  8, 1, 0, 4);

    // A 40-cycle interval puts the edge in the timeout cycle. The edge wins.
    applyStimulus(0, 40, 0, 12, 1, 0, 4);
    applyStimulus(1, 10, 1, 40, 1, 0, 5);

    // Stall: the last edge, then no activity.
    applyStimulus(0,  3, 0, 10, 1, 1, 5);
    for (int i = 0; i < 39; i++) stepCycle();
    checkOutput("pre_stall",       32'(stalled), 0);
    checkOutput("pre_stall_valid", 32'(period_valid), 1);
    stepCycle();
    checkOutput("stall_rise",  32'(stalled), 1);
    checkOutput("stall_valid", 32'(period_valid), 0);
    checkOutput("stall_hp",    32'(half_period), 10);
    for (int i = 0; i < 7; i++) stepCycle();
    checkOutput("stall_hold",  32'(stalled), 1);
    checkOutput("stall_quiet", 32'(edge_any), 0);

    // Recovery: the first edge clears stalled but records nothing.
    applyStimulus(1, 10, 1, 10, 0, 1, 6);
    applyStimulus(0, 10, 0, 10, 1, 1, 6);

    // Seconds wrap: rises 7 through 61 with 5-cycle half-periods.
    rises = 6;
    for (int r = 7; r <= 61; r++) begin
      rises = r;
      applyStimulus(1, 5, 1, (r == 7) ? 10 : 5, 1, (r == 7) ? 1 : 0, r % 60);
      applyStimulus(0, 5, 0, 5, 1, 0, r % 60);
    end
    checkOutput("rise_count", 32'(rises), 61);
    checkOutput("wrap_final", 32'(seconds), 1);

    // Reset while measuring with cnt at 5.
    applyStimulus(1, 3, 1, 5, 1, 0, 1);
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("mid_cnt", 32'(dut.cnt_q), 5);
    Reset   = 1'b1;
    slow_in = 1'b0;
    stepCycle();
    checkAllZero("mid_reset");
    Reset = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("post_reset_edge", 32'(edge_any), 0);
    applyStimulus(1, 10, 1,  0, 0, 0, 1);
    applyStimulus(0, 10, 0, 10, 1, 1, 1);

    // slow_in held high through reset produces one tick after release.
    Reset   = 1'b1;
    slow_in = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("hi_reset_tick",    32'(tick), 0);
    checkOutput("hi_reset_seconds", 32'(seconds), 0);
    Reset = 1'b0;
    applyStimulus(1, 5, 1, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
